// File: rtl/ring_pkg.sv
// ring_pkg: shared definitions for the one-hot ring counter family.
//   state_t    : receiver lock state (HUNT / ACQ / LOCKED)
//   rotr()     : right-rotation {code[0], code[w-1:1]} over the low w bits
//   is_onehot(): exactly one bit set
// Codes are carried zero-extended to MAX_W bits so one function set
// serves every ring length up to MAX_W.
package ring_pkg;

  localparam int unsigned MAX_W = 32;

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_ACQ    = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  typedef enum logic [1:0] {
    HUNT   = ST_HUNT,
    ACQ    = ST_ACQ,
    LOCKED = ST_LOCKED
  } state_t;

  // Bits at and above w must be zero on entry; bit 0 re-enters at w-1.
  function automatic logic [MAX_W-1:0] rotr(input logic [MAX_W-1:0] code,
                                            input int unsigned     w);
    return (code >> 1) | ({{(MAX_W-1){1'b0}}, code[0]} << (w - 1));
  endfunction

  function automatic logic is_onehot(input logic [MAX_W-1:0] code);
    return (code != '0) && ((code & (code - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/ring_decoder_if.sv
// ring_decoder_if: sample/status bundle of the ring decoder.
//   master : drives in_valid, ring_in, err_clr; observes decoder status
//   slave  : the decoder itself
//   in_valid    ring_in is sampled this cycle
//   ring_in     WIDTH-bit ring code
//   err_clr     synchronous clear of err_count
//   index       binary phase, index_valid qualifies it
//   wrap/onehot_err/step_err  one-cycle event pulses
//   locked      decoder is in LOCKED
//   err_count   saturating error event counter
interface ring_decoder_if #(
  parameter int unsigned WIDTH = 4
) ();

  localparam int unsigned IW = $clog2(WIDTH);

  logic             in_valid;
  logic [WIDTH-1:0] ring_in;
  logic             err_clr;
  logic [IW-1:0]    index;
  logic             index_valid;
  logic             wrap;
  logic             onehot_err;
  logic             step_err;
  logic             locked;
  logic [15:0]      err_count;

  modport master (
    output in_valid, ring_in, err_clr,
    input  index, index_valid, wrap, onehot_err, step_err, locked, err_count
  );

  modport slave (
    input  in_valid, ring_in, err_clr,
    output index, index_valid, wrap, onehot_err, step_err, locked, err_count
  );

endinterface

// File: rtl/ring_decoder_onehot_to_bin.sv
// onehot_to_bin: combinational one-hot decoder.
//   i_code   : WIDTH-bit code
//   o_index  : bit position of the set bit (OR of set positions; only
//              meaningful when o_onehot is high)
//   o_onehot : exactly one bit of i_code is set
module onehot_to_bin
  import ring_pkg::*;
#(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned IW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_code,
  output logic [IW-1:0]    o_index,
  output logic             o_onehot
);

  always_comb begin
    o_index = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i_code[i]) o_index = o_index | IW'(i);
    end
    o_onehot = is_onehot(MAX_W'(i_code));
  end

endmodule

// File: rtl/ring_decoder.sv
// ring_decoder: receive end of a one-hot ring counter.
// Checks each valid sample is one-hot and equal to the right-rotation of
// the previous word, decodes it to a binary index and keeps lock with a
// flywheel (predicted phase keeps advancing through bad samples).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ring_decoder_if.slave (sample inputs, status outputs)
// All outputs are registered: a sample taken on edge N shows on the
// outputs after that edge.
module ring_decoder
  import ring_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned LOCK_CNT  = 2,
  parameter int unsigned ERR_LIMIT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  ring_decoder_if.slave  bus
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam int unsigned GW = $clog2(LOCK_CNT + 1);
  localparam int unsigned MW = $clog2(ERR_LIMIT + 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_expected;
  logic [GW-1:0]    r_good_cnt;
  logic [MW-1:0]    r_miss_cnt;
  logic [15:0]      r_err_count;
  logic [IW-1:0]    r_index;
  logic             r_locked;
  logic             r_wrap;
  logic             r_onehot_err;
  logic             r_step_err;

  state_t           w_state_d;
  logic [WIDTH-1:0] w_exp_d;
  logic [WIDTH-1:0] w_exp_next;
  logic [GW-1:0]    w_good_d;
  logic [MW-1:0]    w_miss_d;
  logic [15:0]      w_cnt_d;
  logic             w_wrap_d;
  logic             w_oh_err_d;
  logic             w_step_err_d;
  logic             w_err;
  logic             w_in_oh;
  logic             w_step_ok;
  logic [IW-1:0]    w_in_idx;
  logic [IW-1:0]    w_exp_idx;
  logic             w_exp_oh;

  onehot_to_bin #(.WIDTH(WIDTH)) u_in_dec (
    .i_code   (bus.ring_in),
    .o_index  (w_in_idx),
    .o_onehot (w_in_oh)
  );

  onehot_to_bin #(.WIDTH(WIDTH)) u_exp_dec (
    .i_code   (w_exp_d),
    .o_index  (w_exp_idx),
    .o_onehot (w_exp_oh)
  );

  always_comb begin
    w_exp_next = WIDTH'(rotr(MAX_W'(r_expected), WIDTH));
    w_step_ok  = w_in_oh && (bus.ring_in == w_exp_next);
  end

  always_comb begin
    w_state_d    = r_state;
    w_exp_d      = r_expected;
    w_good_d     = r_good_cnt;
    w_miss_d     = r_miss_cnt;
    w_wrap_d     = 1'b0;
    w_oh_err_d   = 1'b0;
    w_step_err_d = 1'b0;
    if (bus.in_valid) begin
      unique case (r_state)
        HUNT: begin
          if (w_in_oh) begin
            w_state_d = ACQ;
            w_exp_d   = bus.ring_in;
            w_good_d  = '0;
          end else begin
            w_oh_err_d = 1'b1;
          end
        end
        ACQ: begin
          if (w_step_ok) begin
            w_exp_d  = bus.ring_in;
            w_wrap_d = r_expected[0];
            if (r_good_cnt == GW'(LOCK_CNT - 1)) begin
              w_state_d = LOCKED;
              w_good_d  = '0;
              w_miss_d  = '0;
            end else begin
              w_good_d = r_good_cnt + 1'b1;
            end
          end else if (w_in_oh) begin
            // Re-anchor on the new one-hot word and restart qualification.
            w_step_err_d = 1'b1;
            w_exp_d      = bus.ring_in;
            w_good_d     = '0;
          end else begin
            w_oh_err_d = 1'b1;
            w_state_d  = HUNT;
            w_good_d   = '0;
          end
        end
        LOCKED: begin
          // Flywheel: the prediction advances whatever arrives.
          w_exp_d = w_exp_next;
          if (w_step_ok) begin
            w_wrap_d = r_expected[0];
            w_miss_d = '0;
          end else begin
            w_oh_err_d   = !w_in_oh;
            w_step_err_d = w_in_oh;
            if (r_miss_cnt == MW'(ERR_LIMIT - 1)) begin
              w_state_d = HUNT;
              w_miss_d  = '0;
            end else begin
              w_miss_d = r_miss_cnt + 1'b1;
            end
          end
        end
        default: begin
          w_state_d = HUNT;
        end
      endcase
    end
  end

  // A clear coinciding with an error keeps that error as the first count.
  always_comb begin
    w_err   = w_oh_err_d | w_step_err_d;
    w_cnt_d = r_err_count;
    if (bus.err_clr) begin
      w_cnt_d = {15'd0, w_err};
    end else if (w_err && (r_err_count != '1)) begin
      w_cnt_d = r_err_count + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= HUNT;
      r_expected   <= '0;
      r_good_cnt   <= '0;
      r_miss_cnt   <= '0;
      r_err_count  <= '0;
      r_index      <= '0;
      r_locked     <= 1'b0;
      r_wrap       <= 1'b0;
      r_onehot_err <= 1'b0;
      r_step_err   <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_expected   <= w_exp_d;
      r_good_cnt   <= w_good_d;
      r_miss_cnt   <= w_miss_d;
      r_err_count  <= w_cnt_d;
      r_locked     <= (w_state_d == LOCKED);
      r_wrap       <= w_wrap_d;
      r_onehot_err <= w_oh_err_d;
      r_step_err   <= w_step_err_d;
      // expected is only non-one-hot before the first acquisition, where
      // the index already sits at its reset value.
      if (w_exp_oh) r_index <= w_exp_idx;
    end
  end

  assign bus.index       = r_index;
  assign bus.index_valid = r_locked;
  assign bus.locked      = r_locked;
  assign bus.wrap        = r_wrap;
  assign bus.onehot_err  = r_onehot_err;
  assign bus.step_err    = r_step_err;
  assign bus.err_count   = r_err_count;

  // Unused here; decoded index comes from the expected register.
  logic w_unused;
  assign w_unused = ^w_in_idx;

endmodule
